// File: rtl/rd_data_ret_pkg.sv
// Shared definitions for the DDR2 read-return path: FSM state encoding,
// burst geometry and error-flag bit positions.
package rd_data_ret_pkg;

  // 4-bit encoding, same style as the command generator
  typedef enum logic [3:0] {
    IDLE      = 4'h0,
    WAIT_DATA = 4'h1,
    COLLECT   = 4'h2,
    ERR       = 4'hF
  } state_t;

  localparam int unsigned DEF_READ_BURST = 8;
  localparam int unsigned BEATS          = DEF_READ_BURST / 2;

  localparam int unsigned ERR_UNEXP_BIT = 0;
  localparam int unsigned ERR_OVF_BIT   = 1;

  // User-side beats per DDR burst
  function automatic int unsigned beats_of(input int unsigned read_burst);
    return read_burst / 2;
  endfunction

endpackage

// File: rtl/rd_credit_cnt.sv
// Read-command credit counter.
//   inc              : a read command was issued
//   dec              : a burst completed
//   outstanding      : commands in flight
//   outstanding_next : value after this cycle's inc/dec
//   inc_drop         : inc arrived at saturation and was ignored
module rd_credit_cnt
  import rd_data_ret_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] outstanding,
  output logic [3:0] outstanding_next,
  output logic       inc_drop
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic inc_eff;

  // A simultaneous completion frees a slot, so inc at saturation is only
  // dropped when no decrement happens in the same cycle.
  always_comb begin
    inc_drop         = inc && !dec && (outstanding == MAX_CNT);
    inc_eff          = inc && !inc_drop;
    outstanding_next = outstanding;
    if (inc_eff && !dec)
      outstanding_next = outstanding + 4'd1;
    else if (dec && !inc_eff)
      outstanding_next = outstanding - 4'd1;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)
      outstanding <= '0;
    else
      outstanding <= outstanding_next;
  end

endmodule

// File: rtl/rd_data_ret.sv
// Read-return responder: grants read permission, tracks read commands in
// flight, collects returning beats per burst into the output FIFO and flags
// unexpected-data / overflow errors.
//   rd_en/rd_addr           : permission and next address for the cmd generator
//   out_fifo_wr/din         : output FIFO write, 1 cycle after the beat
//   burst_done              : with the write of the last beat of a burst
//   outstanding             : read commands in flight
//   err_unexpected/overflow : sticky error flags
module rd_data_ret
  import rd_data_ret_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned READ_BURST      = DEF_READ_BURST,
  parameter int unsigned ADDR_WIDTH      = 31,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  phy_init_done,
  input  logic                  rd_addr_en,
  input  logic                  app_rd_data_valid,
  input  logic [DATA_WIDTH-1:0] app_rd_data,
  input  logic                  out_fifo_full,
  input  logic                  out_fifo_prog_full,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  out_fifo_wr,
  output logic [DATA_WIDTH-1:0] out_fifo_din,
  output logic                  burst_done,
  output logic [3:0]            outstanding,
  output logic                  err_unexpected,
  output logic                  err_overflow
);

  localparam logic [2:0]            LAST_BEAT = 3'(beats_of(READ_BURST) - 1);
  localparam logic [3:0]            MAX_CNT   = 4'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(READ_BURST);

  state_t     state, state_next;
  logic [2:0] beat_cnt;
  logic [1:0] err_q;
  logic [3:0] outstanding_next;
  logic       in_err, cmd_inc, cmd_drop, accept, last_beat, burst_cmp;
  logic       unexp_now, ovf_now, err_now;

  rd_credit_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .sys_clk          (sys_clk),
    .reset            (reset),
    .inc              (cmd_inc),
    .dec              (burst_cmp),
    .outstanding      (outstanding),
    .outstanding_next (outstanding_next),
    .inc_drop         (cmd_drop)
  );

  always_comb begin
    in_err    = (state == ERR);
    cmd_inc   = rd_addr_en && !in_err;
    accept    = app_rd_data_valid && (outstanding != 4'd0) && !out_fifo_full && !in_err;
    last_beat = (beat_cnt == LAST_BEAT);
    burst_cmp = accept && last_beat;
    unexp_now = app_rd_data_valid && (outstanding == 4'd0);
    ovf_now   = (app_rd_data_valid && out_fifo_full) || cmd_drop;
    err_now   = unexp_now || ovf_now;
  end

  // Burst completion decides the next state directly, so a single-beat burst
  // (READ_BURST = 2) and back-to-back bursts need no extra state.
  always_comb begin
    state_next = state;
    if (state != ERR) begin
      if (accept)
        state_next = !last_beat                  ? COLLECT :
                     (outstanding_next == 4'd0)  ? IDLE    : WAIT_DATA;
      else if (state == IDLE && rd_addr_en && phy_init_done)
        state_next = WAIT_DATA;
    end
    if (err_now)
      state_next = ERR;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      err_q        <= '0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      out_fifo_wr  <= 1'b0;
      out_fifo_din <= '0;
      burst_done   <= 1'b0;
    end else begin
      state       <= state_next;
      out_fifo_wr <= accept;
      burst_done  <= burst_cmp;
      if (accept) begin
        out_fifo_din <= app_rd_data;
        beat_cnt     <= last_beat ? 3'd0 : beat_cnt + 3'd1;
      end
      if (cmd_inc && !cmd_drop)
        rd_addr <= rd_addr + ADDR_STEP;
      if (unexp_now) err_q[ERR_UNEXP_BIT] <= 1'b1;
      if (ovf_now)   err_q[ERR_OVF_BIT]   <= 1'b1;
      rd_en <= phy_init_done && !out_fifo_prog_full && !in_err && !err_now
               && (outstanding_next < MAX_CNT);
    end
  end

  assign err_unexpected = err_q[ERR_UNEXP_BIT];
  assign err_overflow   = err_q[ERR_OVF_BIT];

endmodule

// File: tb/tb_rd_data_ret.sv
module tb_rd_data_ret;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        phy_init_done, rd_addr_en, app_rd_data_valid;
  logic [63:0] app_rd_data;
  logic        out_fifo_full, out_fifo_prog_full;
  logic        rd_en, out_fifo_wr, burst_done, err_unexpected, err_overflow;
  logic [30:0] rd_addr;
  logic [63:0] out_fifo_din;
  logic [3:0]  outstanding;

  // narrow-address instance for the wrap check
  logic        w_phy, w_en, w_zero;
  logic [63:0] w_data;
  logic        w_rd_en, w_wr, w_done, w_eu, w_eo;
  logic [3:0]  w_rd_addr, w_out;
  logic [63:0] w_din;

  rd_data_ret dut (
    .sys_clk(sys_clk), .reset(reset), .phy_init_done(phy_init_done),
    .rd_addr_en(rd_addr_en), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data(app_rd_data), .out_fifo_full(out_fifo_full),
    .out_fifo_prog_full(out_fifo_prog_full), .rd_en(rd_en), .rd_addr(rd_addr),
    .out_fifo_wr(out_fifo_wr), .out_fifo_din(out_fifo_din),
    .burst_done(burst_done), .outstanding(outstanding),
    .err_unexpected(err_unexpected), .err_overflow(err_overflow)
  );

  rd_data_ret #(.ADDR_WIDTH(4)) u_wrap (
    .sys_clk(sys_clk), .reset(reset), .phy_init_done(w_phy),
    .rd_addr_en(w_en), .app_rd_data_valid(w_zero), .app_rd_data(w_data),
    .out_fifo_full(w_zero), .out_fifo_prog_full(w_zero), .rd_en(w_rd_en),
    .rd_addr(w_rd_addr), .out_fifo_wr(w_wr), .out_fifo_din(w_din),
    .burst_done(w_done), .outstanding(w_out), .err_unexpected(w_eu),
    .err_overflow(w_eo)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          due;
  } exp_t;
  exp_t sb[$];

  always @(posedge sys_clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every FIFO write must match the head of the scoreboard
  exp_t e;
  always @(negedge sys_clk) begin
    if (!reset && out_fifo_wr) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_write: got din %0h expected no write", out_fifo_din);
      end else begin
        e = sb.pop_front();
        chk("sb_data", out_fifo_din, e.data);
        chk("sb_burst_done", {63'd0, burst_done}, {63'd0, e.last});
        chk("sb_latency", 64'(cyc), 64'(e.due));
      end
    end else if (!reset && burst_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_stray_burst_done: got 1 expected 0");
    end
  end

  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input bit expect_wr, input bit last);
    app_rd_data_valid = 1'b1;
    app_rd_data       = d;
    if (expect_wr) sb.push_back('{d, last, cyc + 1});
    step();
    app_rd_data_valid = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_rd_en"}, {63'd0, rd_en}, 64'd0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_wr"}, {63'd0, out_fifo_wr}, 64'd0);
    chk({tag, "_outstanding"}, 64'(outstanding), 64'd0);
    chk({tag, "_err_unexp"}, {63'd0, err_unexpected}, 64'd0);
    chk({tag, "_err_ovf"}, {63'd0, err_overflow}, 64'd0);
  endtask

  task automatic do_reset;
    rd_addr_en = 1'b0;
    app_rd_data_valid = 1'b0;
    out_fifo_full = 1'b0;
    out_fifo_prog_full = 1'b0;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    reset = 1'b1;
    #1;
    check_cleared("rst");
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] wexp [3];
    wexp = '{4'd8, 4'd0, 4'd8};
    reset = 1'b1;
    phy_init_done = 1'b0; rd_addr_en = 1'b0; app_rd_data_valid = 1'b0;
    app_rd_data = '0; out_fifo_full = 1'b0; out_fifo_prog_full = 1'b0;
    w_phy = 1'b0; w_en = 1'b0; w_zero = 1'b0; w_data = '0;
    #1;
    check_cleared("init");
    chk("init_din", out_fifo_din, 64'd0);
    chk("init_burst_done", {63'd0, burst_done}, 64'd0);
    step(); step();
    reset = 1'b0;

    // init and single burst
    phy_init_done = 1'b1; w_phy = 1'b1;
    step();
    chk("init_rd_en", {63'd0, rd_en}, 64'd1);
    rd_addr_en = 1'b1; step(); rd_addr_en = 1'b0;
    chk("single_outstanding", 64'(outstanding), 64'd1);
    chk("single_rd_addr", 64'(rd_addr), 64'd8);
    for (int i = 0; i < 4; i++) send_beat(64'hA0 + 64'(i), 1'b1, i == 3);
    chk("single_outstanding_done", 64'(outstanding), 64'd0);
    step();

    // completion and new command in the same cycle
    rd_addr_en = 1'b1; step(); step(); rd_addr_en = 1'b0;
    chk("simul_outstanding_pre", 64'(outstanding), 64'd2);
    for (int i = 0; i < 3; i++) send_beat(64'hB0 + 64'(i), 1'b1, 1'b0);
    rd_addr_en = 1'b1;
    send_beat(64'hB3, 1'b1, 1'b1);
    rd_addr_en = 1'b0;
    chk("simul_outstanding", 64'(outstanding), 64'd2);
    // two bursts back to back at full rate
    for (int i = 0; i < 8; i++) send_beat(64'hC0 + 64'(i), 1'b1, (i % 4) == 3);
    chk("b2b_outstanding", 64'(outstanding), 64'd0);
    chk("b2b_rd_addr", 64'(rd_addr), 64'd32);
    chk("b2b_rd_en", {63'd0, rd_en}, 64'd1);

    // unexpected data
    send_beat(64'hEE, 1'b0, 1'b0);
    chk("unexp_flag", {63'd0, err_unexpected}, 64'd1);
    chk("unexp_rd_en", {63'd0, rd_en}, 64'd0);
    step(); step(); step();
    chk("unexp_rd_en_held", {63'd0, rd_en}, 64'd0);
    chk("unexp_no_ovf", {63'd0, err_overflow}, 64'd0);
    do_reset();

    // credit limit
    step();
    chk("credit_rd_en_start", {63'd0, rd_en}, 64'd1);
    rd_addr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) chk("credit_rd_en_7", {63'd0, rd_en}, 64'd1);
    end
    chk("credit_rd_en_8", {63'd0, rd_en}, 64'd0);
    chk("credit_outstanding_8", 64'(outstanding), 64'd8);
    chk("credit_no_ovf_8", {63'd0, err_overflow}, 64'd0);
    step();
    rd_addr_en = 1'b0;
    chk("credit_outstanding_9", 64'(outstanding), 64'd8);
    chk("credit_err_ovf", {63'd0, err_overflow}, 64'd1);
    chk("credit_no_unexp", {63'd0, err_unexpected}, 64'd0);
    chk("credit_rd_addr", 64'(rd_addr), 64'd64);
    do_reset();

    // FIFO backpressure
    step();
    rd_addr_en = 1'b1; step(); rd_addr_en = 1'b0;
    out_fifo_prog_full = 1'b1;
    step();
    chk("bp_rd_en_drop", {63'd0, rd_en}, 64'd0);
    send_beat(64'hE0, 1'b1, 1'b0);
    send_beat(64'hE1, 1'b1, 1'b0);
    out_fifo_full = 1'b1;
    send_beat(64'hE2, 1'b0, 1'b0);
    out_fifo_full = 1'b0;
    chk("bp_err_ovf", {63'd0, err_overflow}, 64'd1);
    chk("bp_no_unexp", {63'd0, err_unexpected}, 64'd0);
    send_beat(64'hE3, 1'b0, 1'b0);
    chk("bp_frozen_outstanding", 64'(outstanding), 64'd1);
    chk("bp_frozen_no_unexp", {63'd0, err_unexpected}, 64'd0);
    do_reset();

    // reset in the middle of a burst
    step();
    rd_addr_en = 1'b1; step(); rd_addr_en = 1'b0;
    send_beat(64'hF0, 1'b1, 1'b0);
    send_beat(64'hF1, 1'b1, 1'b0);
    @(negedge sys_clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_outstanding", 64'(outstanding), 64'd0);
    chk("midrst_wr", {63'd0, out_fifo_wr}, 64'd0);
    step();
    reset = 1'b0;
    send_beat(64'hF2, 1'b0, 1'b0);
    chk("midrst_late_beat_unexp", {63'd0, err_unexpected}, 64'd1);

    // address wrap with a 4-bit address
    chk("wrap_addr_0", 64'(w_rd_addr), 64'd0);
    for (int i = 0; i < 3; i++) begin
      w_en = 1'b1; step(); w_en = 1'b0;
      chk($sformatf("wrap_addr_%0d", i + 1), 64'(w_rd_addr), 64'(wexp[i]));
    end

    step(); step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
